seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/imhotep_pkg.sv | 48 ++++
 rtl/seq_alu_muldiv.sv | 100 ++++++++++
 rtl/seq_alu.sv | 141 ++++++++++++++
 tb/tb_seq_alu.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imhotep_pkg.sv
// Shared ALU definitions: operation encoding and helpers for the sequential ALU.
package imhotep_pkg;

  // Encodings 0..6 are the original ALU ops and must keep their values.
  // The iterative and extended ops are appended after them.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_JMPR  = 4'd6,
    ALU_MUL   = 4'd7,
    ALU_MULHU = 4'd8,
    ALU_DIVU  = 4'd9,
    ALU_REMU  = 4'd10,
    ALU_SLTU  = 4'd11,
    ALU_SLL   = 4'd12,
    ALU_SRL   = 4'd13,
    ALU_SRA   = 4'd14
  } op_seq_alu_e;

  // Sub-op for the iterative unit. Bit 1 selects divide, bit 0 selects the
  // high half (MULHU) or the remainder (REMU).
  typedef enum logic [1:0] {
    MD_MUL   = 2'd0,
    MD_MULHU = 2'd1,
    MD_DIVU  = 2'd2,
    MD_REMU  = 2'd3
  } md_op_e;

  function automatic logic is_muldiv_op(op_seq_alu_e op);
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  function automatic logic [1:0] to_md_op(op_seq_alu_e op);
    logic [1:0] m;
    case (op)
      ALU_MULHU: m = MD_MULHU;
      ALU_DIVU:  m = MD_DIVU;
      ALU_REMU:  m = MD_REMU;
      default:   m = MD_MUL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply / restoring divide unit. One bit per cycle, exactly
// XLEN iterations after start; done pulses during the last iteration and
// result carries the value that iteration produces.
module seq_alu_muldiv
  import imhotep_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHIFT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [SHIFT_W-1:0] CNT_LAST = SHIFT_W'(XLEN - 1);

  logic              active_q;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   operand_q;   // multiplicand or divisor
  logic [XLEN-1:0]   hi_q;        // product high half / partial remainder
  logic [XLEN-1:0]   lo_q;        // product low half / dividend shifting into quotient
  logic [SHIFT_W-1:0] cnt_q;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   hi_nxt;
  logic [XLEN-1:0]   lo_nxt;
  logic              is_div;

  assign is_div    = op_q[1];
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, operand_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, operand_q};

  // One shift-add or restoring-subtract step on the hi:lo pair.
  always_comb begin
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    if (!is_div) begin
      {hi_nxt, lo_nxt} = {mul_sum, lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      hi_nxt = div_diff[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_nxt = div_shift[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  assign done = active_q && (cnt_q == '0);

  // Pick the half that holds the requested answer after the final step.
  always_comb begin
    case (op_q)
      MD_MULHU, MD_REMU: result = hi_nxt;
      default:           result = lo_nxt;
    endcase
  end

  // Operand load on start, iterate while active, clear on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      op_q      <= '0;
      operand_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
    end else if (flush) begin
      active_q  <= 1'b0;
      operand_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
    end else if (start) begin
      active_q  <= 1'b1;
      op_q      <= md_op;
      operand_q <= md_op[1] ? opb : opa;
      hi_q      <= '0;
      lo_q      <= md_op[1] ? opa : opb;
      cnt_q     <= CNT_LAST;
    end else if (active_q) begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops computed at acceptance, multiply/divide
// handed to the iterative unit. Result is held until the consumer takes it.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | ready for a request (in_ready high)
//   BUSY   | iterative multiply/divide running, XLEN cycles
//   DONE   | result valid, held until out_ready
module seq_alu
  import imhotep_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHIFT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  op_seq_alu_e     op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic               accept;
  logic               div_by_zero;
  logic               use_muldiv;
  logic               md_start;
  logic               md_done;
  logic [1:0]         md_op;
  logic [XLEN-1:0]    md_result;
  logic [XLEN-1:0]    single_res;
  logic [XLEN-1:0]    out_q;
  logic [XLEN-1:0]    sum;
  logic [SHIFT_W-1:0] shamt;
  logic               slt_s;
  logic               slt_u;

  assign accept      = in_valid && in_ready && !flush;
  assign div_by_zero = ((op == ALU_DIVU) || (op == ALU_REMU)) && (in2 == '0);
  assign use_muldiv  = is_muldiv_op(op) && !div_by_zero;
  assign md_start    = accept && use_muldiv;
  assign md_op       = to_md_op(op);
  assign shamt       = in2[SHIFT_W-1:0];
  assign sum         = in1 + in2;
  assign slt_s       = $signed(in1) < $signed(in2);
  assign slt_u       = in1 < in2;

  seq_alu_muldiv #(
    .XLEN    (XLEN),
    .SHIFT_W (SHIFT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .flush  (flush),
    .md_op  (md_op),
    .opa    (in1),
    .opb    (in2),
    .done   (md_done),
    .result (md_result)
  );

  // Single-cycle result; also covers divide-by-zero and undefined encodings.
  always_comb begin
    single_res = '0;
    case (op)
      ALU_ADD:   single_res = sum;
      ALU_SUB:   single_res = in1 - in2;
      ALU_AND:   single_res = in1 & in2;
      ALU_OR:    single_res = in1 | in2;
      ALU_XOR:   single_res = in1 ^ in2;
      ALU_SLT:   single_res = {{(XLEN-1){1'b0}}, slt_s};
      ALU_SLTU:  single_res = {{(XLEN-1){1'b0}}, slt_u};
      ALU_SLL:   single_res = in1 << shamt;
      ALU_SRL:   single_res = in1 >> shamt;
      ALU_SRA:   single_res = $unsigned($signed(in1) >>> shamt);
      ALU_JMPR:  single_res = {sum[XLEN-1:1], 1'b0};
      ALU_DIVU:  single_res = '1;
      ALU_REMU:  single_res = in1;
      default:   single_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = use_muldiv ? S_BUSY : S_DONE;
      S_BUSY: if (md_done) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Result register: loaded when the answer is known, cleared when it leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (flush) begin
      out_q <= '0;
    end else if (state_q == S_IDLE && accept && !use_muldiv) begin
      out_q <= single_res;
    end else if (state_q == S_BUSY && md_done) begin
      out_q <= md_result;
    end else if (state_q == S_DONE && out_ready) begin
      out_q <= '0;
    end
  end

  // Outputs decoded from state; in_ready stays low while reset is held.
  always_comb begin
    in_ready  = rst_n && (state_q == S_IDLE);
    busy      = (state_q == S_BUSY);
    out_valid = (state_q == S_DONE);
    out       = out_valid ? out_q : '0;
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import imhotep_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
  op_seq_alu_e op;
  logic [31:0] in1, in2, out;

  logic        in_valid8, in_ready8, flush8, out_valid8, out_ready8, busy8;
  op_seq_alu_e op8;
  logic [7:0]  a8, b8, out8;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in1(in1), .in2(in2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  seq_alu #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .in1(a8), .in2(b8), .flush(flush8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out(out8), .busy(busy8)
  );

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the arithmetic definitions, width w (8..32).
  function automatic logic [63:0] ref_alu(logic [3:0] o, logic [63:0] a, logic [63:0] b, int w);
    logic [63:0] mask, sa, sb, r;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    sh   = int'(b % 64'(w));
    sa   = a[w-1] ? (a | ~mask) : a;
    sb   = b[w-1] ? (b | ~mask) : b;
    case (o)
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_SLT:   r = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
      ALU_SLTU:  r = (a < b) ? 64'd1 : 64'd0;
      ALU_SLL:   r = a << sh;
      ALU_SRL:   r = a >> sh;
      ALU_SRA:   r = $unsigned($signed(sa) >>> sh);
      ALU_JMPR:  r = (a + b) & ~64'd1;
      ALU_MUL:   r = a * b;
      ALU_MULHU: r = (a * b) >> w;
      ALU_DIVU:  r = (b == 0) ? mask : a / b;
      ALU_REMU:  r = (b == 0) ? a : a % b;
      default:   r = 64'd0;
    endcase
    return r & mask;
  endfunction

  function automatic int latency(logic [3:0] o, logic [63:0] b, int w);
    if (o == ALU_MUL || o == ALU_MULHU) return w + 1;
    if ((o == ALU_DIVU || o == ALU_REMU) && b != 0) return w + 1;
    return 1;
  endfunction

  task automatic run32(logic [3:0] o, logic [31:0] a, logic [31:0] b, int hold, string tag);
    logic [63:0] exp;
    int lat, cyc;
    exp = ref_alu(o, {32'd0, a}, {32'd0, b}, 32);
    lat = latency(o, {32'd0, b}, 32);
    @(negedge clk);
    check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = op_seq_alu_e'(o); in1 = a; in2 = b;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    check({tag, ".busy"}, 64'(busy), (lat > 1) ? 64'd1 : 64'd0);
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(lat));
    check({tag, ".out"}, 64'(out), exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_out"}, 64'(out), exp);
      check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, ".out_zero"}, 64'(out), 64'd0);
    check({tag, ".ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run8(logic [3:0] o, logic [7:0] a, logic [7:0] b, string tag);
    logic [63:0] exp;
    int lat, cyc;
    exp = ref_alu(o, {56'd0, a}, {56'd0, b}, 8);
    lat = latency(o, {56'd0, b}, 8);
    @(negedge clk);
    in_valid8 = 1'b1; op8 = op_seq_alu_e'(o); a8 = a; b8 = b;
    @(negedge clk);
    in_valid8 = 1'b0;
    cyc = 1;
    while (!out_valid8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(lat));
    check({tag, ".out"}, 64'(out8), exp);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check({tag, ".valid_drop"}, 64'(out_valid8), 64'd0);
  endtask

  initial begin
    int seen_valid;
    int cyc;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0;
    in_valid = 1'b0; op = ALU_ADD; in1 = '0; in2 = '0; flush = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; op8 = ALU_ADD; a8 = '0; b8 = '0; flush8 = 1'b0; out_ready8 = 1'b0;

    // Reset state
    #12;
    check("rst.out", 64'(out), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", 64'(in_ready), 64'd1);

    // Directed cases
    run32(ALU_ADD,   32'hFFFF_FFFF, 32'd1,        0, "add_wrap");
    run32(ALU_MUL,   32'h0001_0000, 32'h0001_0000, 0, "mul_lo");
    run32(ALU_MULHU, 32'h0001_0000, 32'h0001_0000, 0, "mulhu");
    run32(ALU_DIVU,  32'd100,       32'd7,        0, "divu");
    run32(ALU_REMU,  32'd100,       32'd7,        0, "remu");
    run32(ALU_DIVU,  32'd5,         32'd0,        0, "divu_zero");
    run32(ALU_REMU,  32'd5,         32'd0,        0, "remu_zero");
    run32(ALU_DIVU,  32'hDEAD_BEEF, 32'd1234,     5, "divu_hold");
    run32(ALU_SUB,   32'd0,         32'd1,        1, "sub_wrap");
    run32(ALU_JMPR,  32'h0000_1001, 32'd2,        0, "jmpr");
    run32(ALU_SRA,   32'h8000_0000, 32'd35,       0, "sra32");
    run32(4'd15,     32'h1234_5678, 32'h1,        0, "undef");

    // Flush mid-MUL: no result, back to IDLE after the flush edge
    @(negedge clk);
    in_valid = 1'b1; op = ALU_MUL; in1 = 32'h1234; in2 = 32'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.in_ready", 64'(in_ready), 64'd1);
    check("flush.busy", 64'(busy), 64'd0);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("flush.no_valid", 64'(seen_valid), 64'd0);

    // Flush blocks acceptance in the same cycle
    in_valid = 1'b1; op = ALU_ADD; in1 = 32'd1; in2 = 32'd1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept.out_valid", 64'(out_valid), 64'd0);
    check("flush_accept.in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset in the middle of a DIVU
    in_valid = 1'b1; op = ALU_DIVU; in1 = 32'd1000; in2 = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid.busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.out_valid", 64'(out_valid), 64'd0);
    check("rst_mid.out", 64'(out), 64'd0);
    check("rst_mid.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid.in_ready_after", 64'(in_ready), 64'd1);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("rst_mid.no_valid", 64'(seen_valid), 64'd0);
    run32(ALU_DIVU, 32'd1000, 32'd3, 0, "after_rst");

    // XLEN = 8 instance
    run8(ALU_SRA,  8'h80, 8'd3,  "sra8");
    run8(ALU_SLT,  8'h80, 8'h01, "slt8");
    run8(ALU_SLTU, 8'h80, 8'h01, "sltu8");
    run8(ALU_MUL,  8'h0F, 8'h11, "mul8");
    run8(ALU_DIVU, 8'd200, 8'd9, "divu8");
    run8(ALU_REMU, 8'd200, 8'd9, "remu8");
    run8(ALU_MULHU, 8'hF0, 8'hF0, "mulhu8");

    // Randomized traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      run32(ro, ra, rb, int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end
    for (int n = 0; n < 20; n++) begin
      ro = 4'($urandom_range(0, 15));
      run8(ro, 8'($urandom), 8'($urandom_range(0, 255)), $sformatf("rnd8_%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
